// File: rtl/delay_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_pkg
// Purpose  : Shared types and constants for the delay-chain tap monitor.
// Revision : 1.0
// ============================================================================
package delay_tap_pkg;

    localparam int CNT_W    = 16;
    localparam int MM_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] RD_T0_LO  = 3'd0;
    localparam logic [2:0] RD_T0_HI  = 3'd1;
    localparam logic [2:0] RD_T1_LO  = 3'd2;
    localparam logic [2:0] RD_T1_HI  = 3'd3;
    localparam logic [2:0] RD_T2_LO  = 3'd4;
    localparam logic [2:0] RD_T2_HI  = 3'd5;
    localparam logic [2:0] RD_MM_CNT = 3'd6;
    localparam logic [2:0] RD_STATUS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/tap_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : tap_sync_edge
// Purpose  : Multi-flop synchroniser for one asynchronous tap, plus a pulse on
//            any change of the synchronised value.
// Revision : 1.0
// ============================================================================
module tap_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic edge_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_i};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign sync_o = r_sync[STAGES-1];
    assign edge_o = r_sync[STAGES-1] ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/delay_tap_monitor.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_monitor
// Purpose  : Windowed toggle counting and disagreement detection on three
//            delay-chain taps, read back a byte at a time.
// Config   : DELAY_TAP_MISMATCH_EN builds the mismatch detector.
// Revision : 1.0
// ============================================================================
module delay_tap_monitor
    import delay_tap_pkg::*;
#(
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MM_LIMIT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       tap_i,
    input  logic             start_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic [2:0]       rd_sel_i,
    output logic [7:0]       rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_near = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t              r_state;
    logic [WIN_W-1:0]    r_down;
    logic [CNT_W-1:0]    r_cnt [3];
    logic [2:0]          w_sync;
    logic [2:0]          w_edge;
    logic [MM_CNT_W-1:0] w_mm_cnt;
    logic [7:0]          w_rd_byte;
    logic                w_measure;
    logic                w_arm;

    for (genvar g = 0; g < 3; g++) begin : g_tap
        tap_sync_edge #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .async_i (tap_i[g]),
            .sync_o  (w_sync[g]),
            .edge_o  (w_edge[g])
        );
    end

    assign w_measure = (r_state == ST_MEASURE);
    assign w_arm     = (r_state == ST_ARM);
    assign busy_o    = w_arm || w_measure;
    assign done_o    = (r_state == ST_DONE);

    // The down-counter is loaded in ARM, so the last MEASURE cycle is the one
    // that sees it at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_down  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) r_state <= ST_ARM;
                end
                ST_ARM: begin
                    r_down  <= window_i;
                    r_state <= (window_i == '0) ? ST_DONE : ST_MEASURE;
                end
                ST_MEASURE: begin
                    r_down <= r_down - WIN_W'(1);
                    if (r_down == WIN_W'(1)) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
            sat_o <= 1'b0;
        end else if (w_measure) begin
            for (int i = 0; i < 3; i++) begin
                if (w_edge[i] && (r_cnt[i] != c_cnt_max)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    if (r_cnt[i] == c_cnt_near) sat_o <= 1'b1;
                end
            end
        end
    end

`ifdef DELAY_TAP_MISMATCH_EN
    localparam int RUN_W = $clog2(MM_LIMIT + 1);

    logic [RUN_W-1:0]    r_run;
    logic [MM_CNT_W-1:0] r_mm_cnt;
    logic                r_mismatch;
    logic                w_disagree;

    assign w_disagree = !((w_sync[0] == w_sync[1]) && (w_sync[1] == w_sync[2]));

    // The run length parks at MM_LIMIT so one long disagreement is one episode.
    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_run      <= '0;
            r_mm_cnt   <= '0;
            r_mismatch <= 1'b0;
        end else if (w_measure && w_disagree) begin
            if (r_run != RUN_W'(MM_LIMIT)) r_run <= r_run + RUN_W'(1);
            if (r_run == RUN_W'(MM_LIMIT - 1)) begin
                r_mismatch <= 1'b1;
                if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + MM_CNT_W'(1);
            end
        end else begin
            r_run <= '0;
        end
    end

    assign mismatch_o = r_mismatch;
    assign w_mm_cnt   = r_mm_cnt;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (^w_sync) ^ (MM_LIMIT > 0);
    assign mismatch_o   = 1'b0;
    assign w_mm_cnt     = '0;
`endif

    always_comb begin
        w_rd_byte = 8'h00;
        case (rd_sel_i)
            RD_T0_LO:  w_rd_byte = r_cnt[0][7:0];
            RD_T0_HI:  w_rd_byte = r_cnt[0][15:8];
            RD_T1_LO:  w_rd_byte = r_cnt[1][7:0];
            RD_T1_HI:  w_rd_byte = r_cnt[1][15:8];
            RD_T2_LO:  w_rd_byte = r_cnt[2][7:0];
            RD_T2_HI:  w_rd_byte = r_cnt[2][15:8];
            RD_MM_CNT: w_rd_byte = w_mm_cnt;
            RD_STATUS: w_rd_byte = {4'b0000, sat_o, mismatch_o, done_o, busy_o};
            default:   w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_o <= 8'h00;
        else     rd_data_o <= w_rd_byte;
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_tap_monitor
// Purpose  : Randomised and directed bench for delay_tap_monitor with a
//            window-level reference model.
// Revision : 1.0
// ============================================================================
module tb_delay_tap_monitor;

    localparam int WW  = 17;
    localparam int S   = 2;
    localparam int LIM = 4;
`ifdef DELAY_TAP_MISMATCH_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    tap_i = 3'b000;
    logic          start_i = 1'b0;
    logic [WW-1:0] window_i = '0;
    logic [2:0]    rd_sel_i = 3'd0;
    logic [7:0]    rd_data_o;
    logic          busy_o, done_o, mismatch_o, sat_o;

    int errors = 0;
    int checks = 0;

    delay_tap_monitor #(
        .WIN_W       (WW),
        .SYNC_STAGES (S),
        .MM_LIMIT    (LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tap_i      (tap_i),
        .start_i    (start_i),
        .window_i   (window_i),
        .rd_sel_i   (rd_sel_i),
        .rd_data_o  (rd_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .mismatch_o (mismatch_o),
        .sat_o      (sat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Synchronised tap in cycle k equals the tap driven in cycle k-S; the
    // window is described by the cycle of ARM and its length.
    int         cyc = 0;
    logic [2:0] hist [16];
    bit         armed = 0;
    int         t_arm = 0;
    int         m_n = 0;
    int         m_cnt [3];
    int         m_mm = 0;
    int         m_run = 0;
    bit         m_valid = 0;
    logic [7:0] exp_rd = 8'h00;
    bit         exp_busy, exp_done, exp_mm, exp_sat;

    initial begin
        for (int i = 0; i < 16; i++) hist[i] = 3'b000;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end

    function automatic int phase(input int k);  // 0 idle, 1 arm, 2 measure, 3 done
        if (!armed) return 0;
        if (k == t_arm) return 1;
        if (k <= t_arm + m_n) return 2;
        return 3;
    endfunction

    function automatic bit any_sat();
        return (m_cnt[0] == 65535) || (m_cnt[1] == 65535) || (m_cnt[2] == 65535);
    endfunction

    function automatic logic [7:0] rd_byte(input logic [2:0] sel, input int ph);
        int v;
        case (sel)
            3'd0: v = m_cnt[0];
            3'd1: v = m_cnt[0] >> 8;
            3'd2: v = m_cnt[1];
            3'd3: v = m_cnt[1] >> 8;
            3'd4: v = m_cnt[2];
            3'd5: v = m_cnt[2] >> 8;
            3'd6: v = m_mm;
            default: v = (any_sat() ? 8 : 0) + ((m_mm > 0) ? 4 : 0)
                         + ((ph == 3) ? 2 : 0) + ((ph == 1 || ph == 2) ? 1 : 0);
        endcase
        return 8'(v & 255);
    endfunction

    function automatic logic [2:0] hist_at(input int k);
        if (k < 0) return 3'b000;
        return hist[k % 16];
    endfunction

    always @(posedge clk) begin
        int j, ph;
        logic [2:0] sy, sp;
        j = cyc;
        hist[j % 16] = tap_i;
        if (rst) begin
            for (int d = 0; d <= S; d++) if (j - d >= 0) hist[(j - d) % 16] = 3'b000;
            armed = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_mm = 0; m_run = 0; exp_rd = 8'h00; m_valid = 1;
        end else begin
            ph = phase(j);
            exp_rd = rd_byte(rd_sel_i, ph);
            sy = hist_at(j - S);
            sp = hist_at(j - S - 1);
            if (ph == 1) begin
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
                m_mm = 0; m_run = 0;
            end else if (ph == 2) begin
                for (int i = 0; i < 3; i++)
                    if (sy[i] != sp[i] && m_cnt[i] < 65535) m_cnt[i]++;
                if (sy != 3'b000 && sy != 3'b111) begin
                    m_run++;
                    if (m_run == LIM && MM_EN && m_mm < 255) m_mm++;
                end else m_run = 0;
            end else m_run = 0;
            if ((ph == 0 || ph == 3) && start_i) begin
                armed = 1; t_arm = j + 1; m_n = int'(window_i);
            end
        end
        cyc = j + 1;
        ph = phase(cyc);
        exp_busy = (ph == 1 || ph == 2);
        exp_done = (ph == 3);
        exp_mm   = (m_mm > 0);
        exp_sat  = any_sat();
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("rd_data", 32'(rd_data_o), 32'(exp_rd));
            check("busy", 32'(busy_o), 32'(exp_busy));
            check("done", 32'(done_o), 32'(exp_done));
            check("mismatch", 32'(mismatch_o), 32'(exp_mm));
            check("sat", 32'(sat_o), 32'(exp_sat));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start(input int n);
        window_i = WW'(n);
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic read_lit(input string name, input logic [2:0] sel, input logic [7:0] exp);
        rd_sel_i = sel;
        tick();
        check(name, 32'(rd_data_o), 32'(exp));
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done_o && n < limit) begin
            tick();
            n++;
        end
        check("done_reached", 32'(done_o), 32'd1);
    endtask

    initial begin
        ticks(3);
        rst = 1'b0;
        tick();

        // Reset state
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        for (int s = 0; s < 8; s++) read_lit("reset_byte", 3'(s), 8'h00);

        // All taps together, 10 toggles every 3 cycles, window 100
        do_start(100);
        check("arm_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ticks(3);
            tap_i = ~tap_i;
        end
        ticks(70);
        check("done_at_101", 32'(done_o), 32'd0);
        tick();
        check("done_at_102", 32'(done_o), 32'd1);
        read_lit("t0_lo_10", 3'd0, 8'd10);
        read_lit("t0_hi_10", 3'd1, 8'd0);
        read_lit("t1_lo_10", 3'd2, 8'd10);
        read_lit("t2_lo_10", 3'd4, 8'd10);
        read_lit("mm_zero", 3'd6, 8'd0);

        // tap1 opposite for 3 then 4 cycles
        ticks(3);
        do_start(60);
        ticks(4);
        tap_i = 3'b010; ticks(3);
        tap_i = 3'b000; ticks(5);
        tap_i = 3'b010; ticks(4);
        tap_i = 3'b000;
        wait_done(100);
        read_lit("mm_count", 3'd6, MM_EN ? 8'd1 : 8'd0);
        check("mm_flag", 32'(mismatch_o), MM_EN ? 32'd1 : 32'd0);
        read_lit("mm_status", 3'd7, MM_EN ? 8'h06 : 8'h02);

        // start mid-MEASURE is ignored
        ticks(2);
        do_start(50);
        ticks(10);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ticks(39);
        check("midstart_busy", 32'(busy_o), 32'd1);
        tick();
        check("midstart_done", 32'(done_o), 32'd1);

        // Window 0
        tap_i = 3'b101;
        do_start(0);
        tick();
        check("win0_done", 32'(done_o), 32'd1);
        for (int s = 0; s < 6; s++) read_lit("win0_cnt", 3'(s), 8'h00);
        read_lit("win0_status", 3'd7, 8'h02);
        tap_i = 3'b000;
        ticks(4);

        // Reset during MEASURE
        do_start(200);
        for (int i = 0; i < 25; i++) begin
            ticks(2);
            tap_i = ~tap_i;
        end
        rd_sel_i = 3'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rd", 32'(rd_data_o), 32'd0);
        for (int s = 0; s < 7; s++) read_lit("rst_cnt", 3'(s), 8'h00);
        tap_i = 3'b000;
        ticks(4);

        // Randomised windows, taps, reads and stray starts/resets
        for (int it = 0; it < 30; it++) begin
            int n;
            n = $urandom_range(0, 150);
            do_start(n);
            for (int c = 0; c < n + 20; c++) begin
                rd_sel_i = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    0: tap_i = ~tap_i;
                    1: tap_i = 3'($urandom);
                    2: tap_i[$urandom_range(0, 2)] = ~tap_i[$urandom_range(0, 2)];
                    default: ;
                endcase
                start_i = ($urandom_range(0, 49) == 0);
                rst     = ($urandom_range(0, 999) == 0);
                tick();
            end
            start_i = 1'b0;
            rst     = 1'b0;
        end

        // Saturation: tap0 toggling every cycle for a 70000-cycle window
        tap_i = 3'b000;
        ticks(5);
        do_start(70000);
        for (int c = 0; c < 70010; c++) begin
            tap_i[0] = ~tap_i[0];
            tick();
        end
        wait_done(100);
        read_lit("sat_lo", 3'd0, 8'hFF);
        read_lit("sat_hi", 3'd1, 8'hFF);
        check("sat_flag", 32'(sat_o), 32'd1);
        read_lit("sat_status", 3'd7, 8'h0A);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
